// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the transmit and receive paths.
//               It holds the frame geometry constants, the transmitter state
//               encoding and a parity helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 11;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity is the plain XOR of the data bits. Odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data,
                                     input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter. It counts 0..CLKS_PER_BIT-1 and pulses
//               bit_done for one clock on the final count of every bit.
//               restart forces the count back to 0 so a new frame is aligned
//               to its accept edge.
// Ports       : clk      - system clock
//               reset    - asynchronous active-low reset
//               restart  - realign the count to 0 at the next edge
//               bit_done - high during the last clock of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == C_LAST);

  // The count wraps to 0 on the last clock, so it never passes C_LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (restart || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A restart overrides any coincident terminal count.
  assign bit_done = w_last && !restart;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_parity
// Description : UART transmitter. A frame is 1 start bit, 8 data bits sent
//               LSB first, 1 parity bit and 1 stop bit. Each bit lasts
//               CLKS_PER_BIT clocks. All outputs are registered. A request is
//               accepted only in IDLE. The byte and its parity are latched at
//               that edge.
// Ports       : clk         - system clock
//               reset       - asynchronous active-low reset
//               tx_data     - byte to send, sampled at accept
//               tx_start    - send request, pulse or level
//               clear_irq   - clears tx_done_irq at an edge
//               tx_busy     - frame in flight
//               tx_done_irq - sticky frame-complete flag
//               serial_out  - serial line, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  input  logic                 clear_irq,
  output logic                 tx_busy,
  output logic                 tx_done_irq,
  output logic                 serial_out
);

  localparam int             BIT_CNT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] C_LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic           C_ODD        = (PARITY_ODD != 0);

  tx_state_t                r_state,   w_state_next;
  logic [DATA_BITS-1:0]     r_shreg,   w_shreg_next;
  logic [BIT_CNT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic                     r_parity,  w_parity_next;
  logic                     r_serial,  w_serial_next;
  logic                     r_busy,    w_busy_next;
  logic                     r_irq,     w_irq_next;
  logic                     w_accept;
  logic                     w_bit_done;
  logic                     w_frame_done;

  assign w_accept = (r_state == IDLE) && tx_start;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .reset    (reset),
    .restart  (w_accept),
    .bit_done (w_bit_done)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_serial  <= 1'b1;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_parity  <= w_parity_next;
      r_serial  <= w_serial_next;
      r_busy    <= w_busy_next;
      r_irq     <= w_irq_next;
    end
  end

  // Next-state and next-output logic. Outputs are computed one edge ahead
  // so that the registered line changes on the same edge as the state.
  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_parity_next  = r_parity;
    w_serial_next  = r_serial;
    w_busy_next    = r_busy;
    w_frame_done   = 1'b0;

    case (r_state)
      IDLE: begin
        w_serial_next = 1'b1;
        w_busy_next   = 1'b0;
        if (tx_start) begin
          w_state_next   = START;
          w_shreg_next   = tx_data;
          w_parity_next  = parity_of(tx_data, C_ODD);
          w_bit_cnt_next = '0;
          w_serial_next  = 1'b0;
          w_busy_next    = 1'b1;
        end
      end

      START: begin
        if (w_bit_done) begin
          w_state_next  = DATA;
          w_serial_next = r_shreg[0];
        end
      end

      DATA: begin
        if (w_bit_done) begin
          if (r_bit_cnt == C_LAST_BIT) begin
            w_state_next  = PARITY;
            w_serial_next = r_parity;
          end else begin
            // Shift once per bit. The new LSB is the next bit on the line.
            w_shreg_next   = {1'b0, r_shreg[DATA_BITS-1:1]};
            w_serial_next  = r_shreg[1];
            w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (w_bit_done) begin
          w_state_next  = STOP;
          w_serial_next = 1'b1;
        end
      end

      STOP: begin
        if (w_bit_done) begin
          w_state_next  = IDLE;
          w_busy_next   = 1'b0;
          w_serial_next = 1'b1;
          w_frame_done  = 1'b1;
        end
      end

      default: begin
        w_state_next  = IDLE;
        w_serial_next = 1'b1;
        w_busy_next   = 1'b0;
      end
    endcase

    // A completing frame takes priority over a coincident clear.
    w_irq_next = w_frame_done | (r_irq & ~clear_irq);
  end

  assign serial_out  = r_serial;
  assign tx_busy     = r_busy;
  assign tx_done_irq = r_irq;

endmodule : uart_tx_parity
`default_nettype wire
